// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and constants for the two-requester arbiter/sequencer that sits
// in front of one 16-bit x 256-word single-port OpenRAM macro.
//   - arb_state_e : sequencer state (zero-fill, then normal arbitration)
//   - owner_e     : which requester issued a read
//   - SRAM_DW / SRAM_AW : macro word and address widths
//   - SRAM_RD_LAT : cycles from read grant to the read-data strobe
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int SRAM_DW     = 16;
    localparam int SRAM_AW     = 8;
    localparam int SRAM_RD_LAT = 2;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

endpackage : sram_arb_pkg

// File: rtl/sram_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// sram_rd_tag_pipe
// Valid+owner shift register that follows each read from grant to data return.
// A tag is pushed in the grant cycle and advances one stage per clock.
//   clk0, rst        : clock, asynchronous active-high reset (clears all valids)
//   push_valid       : a read was granted this cycle
//   push_owner       : requester that owns that read
//   cap_valid/owner  : tag in the second-to-last stage; the macro's dout is
//                      valid for this tag, so the parent captures it now
//   out_valid/owner  : tag in the last stage; this is the read-data strobe
// DEPTH must be at least 2.
// -----------------------------------------------------------------------------
module sram_rd_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = SRAM_RD_LAT
)
(
    input  logic   clk0,
    input  logic   rst,
    input  logic   push_valid,
    input  owner_e push_owner,
    output logic   cap_valid,
    output owner_e cap_owner,
    output logic   out_valid,
    output owner_e out_owner
);

    logic [DEPTH-1:0] valid_r;
    owner_e           owner_r [DEPTH];

    // Shift the valid/owner tags one stage per cycle; reset drops every tag.
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                owner_r[i] <= OWN_A;
            end
        end else begin
            valid_r    <= {valid_r[DEPTH-2:0], push_valid};
            owner_r[0] <= push_owner;
            for (int i = 1; i < DEPTH; i++) begin
                owner_r[i] <= owner_r[i-1];
            end
        end
    end

    assign cap_valid = valid_r[DEPTH-2];
    assign cap_owner = owner_r[DEPTH-2];
    assign out_valid = valid_r[DEPTH-1];
    assign out_owner = owner_r[DEPTH-1];

endmodule : sram_rd_tag_pipe

// File: rtl/sram_arb_16_256.sv
// -----------------------------------------------------------------------------
// sram_arb_16_256
// Arbiter and sequencer for one single-RW-port 16x256 OpenRAM macro used as a
// DNN layer buffer. After reset it zero-fills the whole macro, then grants the
// port to requester A or B each cycle and returns registered read data tagged
// to the requester that issued the read (2 cycles after the grant).
//
// Build option:
//   SRAM_ARB_RR_EN defined   : round-robin on conflicts (1-bit pointer)
//   SRAM_ARB_RR_EN undefined : fixed priority, A always wins a conflict
//
// Ports:
//   clk0                : clock (also clocks the macro)
//   rst                 : asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata : requester A access (we=1 write, 0 read)
//   a_gnt               : combinational accept for A this cycle
//   a_rvalid/a_rdata    : registered read-data strobe and data for A
//   b_*                 : same set for requester B
//   sram_csb0/web0/addr0/din0 : macro control/address/data (csb/web active low)
//   sram_dout0          : macro read data
//   init_done           : high once the zero-fill has finished
// -----------------------------------------------------------------------------
module sram_arb_16_256
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = SRAM_DW,
    parameter int ADDR_WIDTH = SRAM_AW
)
(
    input  logic                  clk0,
    input  logic                  rst,

    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,

    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,

    output logic                  init_done
);

    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    arb_state_e            state_r;
    arb_state_e            state_nxt_s;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic                  init_done_r;

    logic                  contend_s;
    logic                  a_wins_s;
    logic                  a_gnt_s;
    logic                  b_gnt_s;

    logic                  sram_csb_s;
    logic                  sram_web_s;
    logic [ADDR_WIDTH-1:0] sram_addr_s;
    logic [DATA_WIDTH-1:0] sram_din_s;
    logic [ADDR_WIDTH-1:0] addr_last_r;
    logic [DATA_WIDTH-1:0] din_last_r;

    logic                  rd_push_s;
    owner_e                rd_owner_s;
    logic                  cap_valid_s;
    owner_e                cap_owner_s;
    logic                  out_valid_s;
    owner_e                out_owner_s;

    logic [DATA_WIDTH-1:0] a_rdata_r;
    logic [DATA_WIDTH-1:0] b_rdata_r;

    // -------------------------------------------------------------------------
    // Sequencer: INIT sweeps every address once, then RUN forever.
    // -------------------------------------------------------------------------

    // Next-state logic: leave INIT right after the last address is issued.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            INIT: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = INIT;
                end
            end
            RUN: begin
                state_nxt_s = RUN;
            end
            default: begin
                state_nxt_s = INIT;
            end
        endcase
    end

    // State register, fill counter and the init_done flag.
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            state_r     <= INIT;
            cnt_r       <= {ADDR_WIDTH{1'b0}};
            init_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            init_done_r <= (state_nxt_s == RUN);
            if (state_r == INIT) begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    assign contend_s = (state_r == RUN) && a_req && b_req;

`ifdef SRAM_ARB_RR_EN
    owner_e rr_ptr_r;

    // Round-robin pointer: after a contended grant it names the loser.
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= OWN_A;
        end else if (contend_s) begin
            rr_ptr_r <= a_wins_s ? OWN_B : OWN_A;
        end
    end

    assign a_wins_s = (rr_ptr_r == OWN_A);
`else
    assign a_wins_s = 1'b1;
`endif

    // Grant decode; nothing is granted while the fill is running.
    always_comb begin
        a_gnt_s = 1'b0;
        b_gnt_s = 1'b0;
        if (state_r == RUN) begin
            a_gnt_s = a_req && (!b_req || a_wins_s);
            b_gnt_s = b_req && (!a_req || !a_wins_s);
        end else begin
            a_gnt_s = 1'b0;
            b_gnt_s = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Macro port mux. When idle the address/data lines hold their last value
    // so the macro inputs do not toggle needlessly.
    // -------------------------------------------------------------------------

    // Drive the macro from the fill counter or the granted requester.
    always_comb begin
        sram_csb_s  = 1'b1;
        sram_web_s  = 1'b1;
        sram_addr_s = addr_last_r;
        sram_din_s  = din_last_r;
        rd_push_s   = 1'b0;
        rd_owner_s  = OWN_A;
        case (state_r)
            INIT: begin
                sram_csb_s  = 1'b0;
                sram_web_s  = 1'b0;
                sram_addr_s = cnt_r;
                sram_din_s  = {DATA_WIDTH{1'b0}};
            end
            RUN: begin
                if (a_gnt_s) begin
                    sram_csb_s  = 1'b0;
                    sram_web_s  = ~a_we;
                    sram_addr_s = a_addr;
                    sram_din_s  = a_wdata;
                    rd_push_s   = ~a_we;
                    rd_owner_s  = OWN_A;
                end else if (b_gnt_s) begin
                    sram_csb_s  = 1'b0;
                    sram_web_s  = ~b_we;
                    sram_addr_s = b_addr;
                    sram_din_s  = b_wdata;
                    rd_push_s   = ~b_we;
                    rd_owner_s  = OWN_B;
                end else begin
                    sram_csb_s  = 1'b1;
                    sram_web_s  = 1'b1;
                end
            end
            default: begin
                sram_csb_s = 1'b1;
                sram_web_s = 1'b1;
            end
        endcase
    end

    // Remember the last driven address/data for idle cycles.
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            addr_last_r <= {ADDR_WIDTH{1'b0}};
            din_last_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            addr_last_r <= sram_addr_s;
            din_last_r  <= sram_din_s;
        end
    end

    // -------------------------------------------------------------------------
    // Read return path
    // -------------------------------------------------------------------------
    sram_rd_tag_pipe #(
        .DEPTH      (SRAM_RD_LAT)
    ) u_tag_pipe (
        .clk0       (clk0),
        .rst        (rst),
        .push_valid (rd_push_s),
        .push_owner (rd_owner_s),
        .cap_valid  (cap_valid_s),
        .cap_owner  (cap_owner_s),
        .out_valid  (out_valid_s),
        .out_owner  (out_owner_s)
    );

    // Capture the macro output into the owner's data register; the other
    // requester's data register keeps its value.
    always_ff @(posedge clk0 or posedge rst) begin
        if (rst) begin
            a_rdata_r <= {DATA_WIDTH{1'b0}};
            b_rdata_r <= {DATA_WIDTH{1'b0}};
        end else if (cap_valid_s) begin
            if (cap_owner_s == OWN_A) begin
                a_rdata_r <= sram_dout0;
            end else begin
                b_rdata_r <= sram_dout0;
            end
        end
    end

    assign a_gnt      = a_gnt_s;
    assign b_gnt      = b_gnt_s;
    assign a_rvalid   = out_valid_s && (out_owner_s == OWN_A);
    assign b_rvalid   = out_valid_s && (out_owner_s == OWN_B);
    assign a_rdata    = a_rdata_r;
    assign b_rdata    = b_rdata_r;
    assign sram_csb0  = sram_csb_s;
    assign sram_web0  = sram_web_s;
    assign sram_addr0 = sram_addr_s;
    assign sram_din0  = sram_din_s;
    assign init_done  = init_done_r;

endmodule : sram_arb_16_256

// File: doc/sram_arb_16_256.md
# sram_arb_16_256

Two-requester arbiter and sequencer for one 16-bit × 256-word single-RW-port OpenRAM macro (`*_sram_16_256_sky130A`) used as a DNN layer buffer. It does three things:
- Zero-fills the macro after reset.
- Grants the port to one of two requesters per cycle, e.g. a weight/feature loader on port A and a compute-engine fetcher on port B.
- Tracks read latency and returns registered read data tagged to the requester that issued the read.

## Interface
Parameters:
- `DATA_WIDTH`, 16: word width.
- `ADDR_WIDTH`, 8: address width; depth is `1<<ADDR_WIDTH`.

Ports:
- `clk0`, in, 1: clock; also drives the macro's `clk0`.
- `rst`, in, 1: asynchronous, active-high reset.
- `a_req`, in, 1: requester A wants an access this cycle.
- `a_we`, in, 1: 1 = write, 0 = read.
- `a_addr`, in, ADDR_WIDTH: word address.
- `a_wdata`, in, DATA_WIDTH: write data.
- `a_gnt`, out, 1: combinational; request accepted this cycle.
- `a_rvalid`, out, 1: registered read-data strobe for A.
- `a_rdata`, out, DATA_WIDTH: registered read data.
- `b_*`: identical set for requester B.
- `sram_csb0`, out, 1: to macro `csb0`, active low.
- `sram_web0`, out, 1: to macro `web0`, active low.
- `sram_addr0`, out, ADDR_WIDTH: to macro `addr0`.
- `sram_din0`, out, DATA_WIDTH: to macro `din0`.
- `sram_dout0`, in, DATA_WIDTH: from macro `dout0`.
- `init_done`, out, 1: high once zero-fill has completed.

## Operation
FSM states: `INIT` and `RUN`.

`INIT` state:
- Entered on reset; an 8-bit counter starts at 0.
- Each cycle drives a write: `sram_csb0=0`, `sram_web0=0`, `sram_addr0=cnt`, `sram_din0=0`.
- The counter increments each cycle. After address 255 is issued, the FSM moves to `RUN` and `init_done` rises the next cycle.
- `a_gnt` and `b_gnt` stay 0; requests are ignored and not queued.

`RUN` state:
- With exactly one of `a_req`/`b_req` high, that requester is granted.
- With both high, the winner comes from the arbitration policy (see Configuration); the loser sees `gnt=0` and must hold its request.
- The granted requester's `we`/`addr`/`wdata` are muxed combinationally onto the `sram_*` outputs. `sram_web0 = ~we`.
- With no request: `sram_csb0=1`, `sram_web0=1`; `sram_addr0` and `sram_din0` keep their last driven values.
- A read grant pushes an owner tag into a 2-stage valid/owner shift pipe.
- When the tag exits the pipe, the block captures `sram_dout0` into the owner's `rdata` and pulses that owner's `rvalid` for one cycle. The other requester's `rdata` is unchanged.
- A write grant produces no `rvalid`.

Reset values:
- All `gnt` and `rvalid` outputs: 0.
- All `rdata` outputs: 0.
- `init_done`: 0.
- `sram_csb0`: 0, because `INIT` starts immediately.
- `sram_web0`: 0, `sram_addr0`: 0, `sram_din0`: 0.
- Round-robin pointer: favours A.
- Pipe valids: 0.

Reset asserted mid-operation:
- Pipe contents are discarded.
- `INIT` restarts at address 0.
- Reads already in flight never produce `rvalid`.

## Timing
Cycle n is the interval between clock edge n and edge n+1.

Read latency:
- Grant in cycle n; the macro registers its inputs at edge n+1.
- The macro reads at the negedge inside cycle n+1, and `sram_dout0` is stable before edge n+2.
- The block samples `sram_dout0` at edge n+2, before the macro's T_HOLD X-window.
- `rvalid` is high in cycle n+2, so read latency from grant is 2 cycles.

Throughput and ordering:
- Throughput is one access per cycle, in any mix of reads and writes and any mix of requesters.
- Write in cycle n, then a read of the same address in cycle n+1: the read returns the new data, because the macro writes at the negedge inside cycle n+1.
- Back-to-back reads by A and B in consecutive cycles give `a_rvalid` and `b_rvalid` in consecutive cycles, in grant order.

`INIT` duration:
- 256 cycles after reset deassertion.
- `init_done` is high from cycle 257 onward.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer names the requester favoured on the next conflict.
  - After a contended grant, the pointer moves to the loser.
  - Uncontended grants leave the pointer unchanged.
- `SRAM_ARB_RR_EN` undefined: fixed priority; A always wins a conflict. The pointer register is not built.

## Structure
- Shared package `sram_arb_pkg` holds:
  - state enum `{INIT, RUN}`;
  - owner enum `{OWN_A, OWN_B}`;
  - constants `SRAM_DW=16`, `SRAM_AW=8`, `SRAM_RD_LAT=2`.
- One natural sub-module, `sram_rd_tag_pipe`: the parameterised-depth valid+owner shift register that produces the `rvalid` strobes.
- The macro itself is instantiated outside this block.

## Test plan
- **Reset and init:** release `rst` → 256 consecutive writes of 0 to addresses 0..255, `gnt` stays low throughout, `init_done` rises at cycle 257.
- **Write then read:**
  - A writes `0xBEEF` to address `0x12` in cycle n.
  - A reads `0x12` in cycle n+1.
  - Required: `a_rvalid` high in cycle n+3 with `a_rdata=0xBEEF`; `b_rvalid` stays 0.
- **Contention (`SRAM_ARB_RR_EN` defined):**
  - A and B both read every cycle for 4 cycles.
  - Required grants: A, B, A, B; `rvalid` alternates A, B, A, B starting 2 cycles after the first grant.
- **Contention (macro undefined):** same stimulus → A granted in all 4 cycles, B never granted, `b_rvalid` stays 0.
- **Mixed owners:**
  - B writes `0x0001` to address `0xFF`.
  - A reads `0xFF` next cycle → `a_rdata=0x0001`.
  - An untouched address reads as `0x0000`.
- **Reset mid-read:**
  - Assert `rst` in the cycle after a read grant.
  - Required: no `rvalid`, `INIT` restarts at address 0, and `rdata` outputs are 0.
